mf_peak_trigger: RTL and testbench



---
 rtl/mf_peak_trigger_if.sv | 20 ++
 rtl/mf_peak_trigger.sv | 140 ++++++++++++++
 tb/tb_mf_peak_trigger.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mf_peak_trigger_if.sv
// mf_peak_trigger_if: sample, config and trigger-result signals of mf_peak_trigger.
interface mf_peak_trigger_if #(
  parameter int INBITS    = 16,
  parameter int TS_BITS   = 32,
  parameter int HOLD_BITS = 8
);
  logic signed [INBITS-1:0] in0_i;
  logic signed [INBITS-1:0] in1_i;
  logic [INBITS-1:0]        thresh_i;
  logic [HOLD_BITS-1:0]     holdoff_i;
  logic                     arm_i;
  logic                     armed_o;
  logic                     trig_o;
  logic [INBITS-1:0]        peak_o;
  logic [TS_BITS:0]         peak_idx_o;
  modport master (output in0_i, in1_i, thresh_i, holdoff_i, arm_i,
                  input  armed_o, trig_o, peak_o, peak_idx_o);
  modport slave  (input  in0_i, in1_i, thresh_i, holdoff_i, arm_i,
                  output armed_o, trig_o, peak_o, peak_idx_o);
endinterface

// File: rtl/mf_peak_trigger.sv
// mf_peak_trigger: two-lane threshold/peak-track/holdoff trigger with sample timestamps.
// Define MF_TRIG_ABS_EN to trigger on |x| (saturating) instead of positive excursions only.
module mf_peak_trigger #(
  parameter int INBITS    = 16,
  parameter int TS_BITS   = 32,
  parameter int HOLD_BITS = 8,
  parameter int TRACK_MAX = 16
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  mf_peak_trigger_if.slave   bus
);
  typedef enum logic [1:0] {DISARMED, ARMED, TRACK, HOLDOFF} state_t;

  function automatic logic [INBITS-1:0] mag(input logic signed [INBITS-1:0] x);
`ifdef MF_TRIG_ABS_EN
    mag = !x[INBITS-1] ? x :
          (x == {1'b1, {(INBITS-1){1'b0}}}) ? {1'b0, {(INBITS-1){1'b1}}} : INBITS'(-x);
`else
    mag = x[INBITS-1] ? '0 : x;
`endif
  endfunction

  state_t                   state_q, state_d;
  logic signed [INBITS-1:0] in0_q, in0_d, in1_q, in1_d;
  logic [TS_BITS-1:0]       cnt_q, cnt_d, ts0_q, ts0_d, ts1_q, ts1_d;
  logic [INBITS-1:0]        m0_q, m0_d, m1_q, m1_d;
  logic                     ex0_q, ex0_d, ex1_q, ex1_d;
  logic [INBITS-1:0]        pk_q, pk_d, peak_q, peak_d;
  logic [TS_BITS:0]         pki_q, pki_d, peak_idx_q, peak_idx_d;
  logic [7:0]               tcnt_q, tcnt_d;
  logic [HOLD_BITS-1:0]     hcnt_q, hcnt_d;
  logic                     trig_q, trig_d, armed_q, armed_d;
  logic [INBITS-1:0]        b_pk, c_pk, n_pk;
  logic [TS_BITS:0]         c_idx, n_idx;
  logic                     u0, u1, any;

  always_comb begin
    in0_d = bus.in0_i;
    in1_d = bus.in1_i;
    ts0_d = cnt_q;
    cnt_d = cnt_q + 1'b1;
    m0_d  = mag(in0_q);
    m1_d  = mag(in1_q);
    ex0_d = m0_d > bus.thresh_i;
    ex1_d = m1_d > bus.thresh_i;
    ts1_d = ts0_q;
    // A fresh event starts from 0 so the strict compare gives lane 0 on ties
    b_pk  = (state_q == TRACK) ? pk_q : '0;
    u0    = ex0_q && (m0_q > b_pk);
    c_pk  = u0 ? m0_q : b_pk;
    c_idx = u0 ? {ts1_q, 1'b0} : pki_q;
    u1    = ex1_q && (m1_q > c_pk);
    n_pk  = u1 ? m1_q : c_pk;
    n_idx = u1 ? {ts1_q, 1'b1} : c_idx;
    any   = ex0_q | ex1_q;
    state_d    = state_q;
    pk_d       = pk_q;
    pki_d      = pki_q;
    tcnt_d     = tcnt_q;
    hcnt_d     = hcnt_q;
    trig_d     = 1'b0;
    peak_d     = peak_q;
    peak_idx_d = peak_idx_q;
    case (state_q)
      DISARMED: state_d = bus.arm_i ? ARMED : DISARMED;
      ARMED: begin
        state_d = !bus.arm_i ? DISARMED : any ? TRACK : ARMED;
        pk_d    = n_pk;
        pki_d   = n_idx;
        tcnt_d  = 8'd1;
      end
      TRACK: begin
        pk_d   = n_pk;
        pki_d  = n_idx;
        tcnt_d = tcnt_q + 8'd1;
        if (!any || tcnt_d == 8'(TRACK_MAX)) begin
          trig_d     = 1'b1;
          peak_d     = n_pk;
          peak_idx_d = n_idx;
          hcnt_d     = bus.holdoff_i;
          state_d    = HOLDOFF;
        end
      end
      HOLDOFF: begin
        hcnt_d  = hcnt_q - 1'b1;
        state_d = (hcnt_q != '0) ? HOLDOFF : bus.arm_i ? ARMED : DISARMED;
      end
      default: state_d = DISARMED;
    endcase
    armed_d = (state_d == ARMED) || (state_d == TRACK);
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q    <= DISARMED;
      in0_q      <= '0;
      in1_q      <= '0;
      cnt_q      <= '0;
      ts0_q      <= '0;
      ts1_q      <= '0;
      m0_q       <= '0;
      m1_q       <= '0;
      ex0_q      <= 1'b0;
      ex1_q      <= 1'b0;
      pk_q       <= '0;
      pki_q      <= '0;
      tcnt_q     <= '0;
      hcnt_q     <= '0;
      trig_q     <= 1'b0;
      armed_q    <= 1'b0;
      peak_q     <= '0;
      peak_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      in0_q      <= in0_d;
      in1_q      <= in1_d;
      cnt_q      <= cnt_d;
      ts0_q      <= ts0_d;
      ts1_q      <= ts1_d;
      m0_q       <= m0_d;
      m1_q       <= m1_d;
      ex0_q      <= ex0_d;
      ex1_q      <= ex1_d;
      pk_q       <= pk_d;
      pki_q      <= pki_d;
      tcnt_q     <= tcnt_d;
      hcnt_q     <= hcnt_d;
      trig_q     <= trig_d;
      armed_q    <= armed_d;
      peak_q     <= peak_d;
      peak_idx_q <= peak_idx_d;
    end
  end

  assign bus.trig_o     = trig_q;
  assign bus.armed_o    = armed_q;
  assign bus.peak_o     = peak_q;
  assign bus.peak_idx_o = peak_idx_q;
endmodule

// File: tb/tb_mf_peak_trigger.sv
// tb_mf_peak_trigger: directed scoreboard bench for mf_peak_trigger (TRACK_MAX=4).
module tb_mf_peak_trigger;
  localparam int INBITS = 16, TS_BITS = 32, HOLD_BITS = 8, TRACK_MAX = 4;

  typedef struct {
    logic [INBITS-1:0]  pk;
    logic [TS_BITS:0]   idx;
    logic [TS_BITS-1:0] due;
  } exp_t;

  logic clk = 1'b0;
  logic rstn_i;
  logic [TS_BITS-1:0] ecnt = '0;
  logic [TS_BITS-1:0] last_ts, p, tt, s;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mf_peak_trigger_if #(.INBITS(INBITS), .TS_BITS(TS_BITS), .HOLD_BITS(HOLD_BITS)) bus ();

  mf_peak_trigger #(.INBITS(INBITS), .TS_BITS(TS_BITS), .HOLD_BITS(HOLD_BITS),
                    .TRACK_MAX(TRACK_MAX)) dut (.clk_i(clk), .rstn_i(rstn_i), .bus(bus));

  // Reference timestamp: value the sample counter presents at each edge
  always @(posedge clk) ecnt <= rstn_i ? ecnt + 1 : '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pair(input int a, input int b);
    bus.in0_i = 16'(a);
    bus.in1_i = 16'(b);
    last_ts = ecnt;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) pair(0, 0);
  endtask

  task automatic push(input int pk, input logic [TS_BITS-1:0] ts, input logic lane,
                      input logic [TS_BITS-1:0] due);
    exp_t e;
    e.pk = 16'(pk);
    e.idx = {ts, lane};
    e.due = due;
    sb.push_back(e);
  endtask

  task automatic check_reset_outputs();
    check("rst_trig", 64'(bus.trig_o), 64'd0);
    check("rst_armed", 64'(bus.armed_o), 64'd0);
    check("rst_peak", 64'(bus.peak_o), 64'd0);
    check("rst_idx", 64'(bus.peak_idx_o), 64'd0);
  endtask

  always @(negedge clk) begin
    if (bus.trig_o === 1'b1) begin
      if (sb.size() == 0) check("unexpected_trig", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("peak", 64'(bus.peak_o), 64'(e.pk));
        check("peak_idx", 64'(bus.peak_idx_o), 64'(e.idx));
        check("trig_time", 64'(ecnt), 64'(e.due));
        check("armed_at_trig", 64'(bus.armed_o), 64'd0);
      end
    end
  end

  initial begin
    rstn_i = 1'b0;
    bus.arm_i = 1'b0;
    bus.in0_i = '0;
    bus.in1_i = '0;
    bus.thresh_i = 16'd100;
    bus.holdoff_i = '0;
    repeat (3) begin
      @(negedge clk);
      check_reset_outputs();
    end
    rstn_i = 1'b1;
    bus.arm_i = 1'b1;
    check("armed_before", 64'(bus.armed_o), 64'd0);
    idle(2);
    check("armed_after_arm", 64'(bus.armed_o), 64'd1);
    idle(5);
    // Single event: peak 300 on lane 0 of the second pair
    pair(50, 120);
    pair(300, 200);
    p = last_ts;
    pair(10, 10);
    push(300, p, 1'b0, last_ts + 3);
    idle(6);
    // Equal lanes resolve to lane 0; a later equal value does not move the peak
    pair(150, 150);
    p = last_ts;
    pair(0, 150);
    pair(0, 0);
    push(150, p, 1'b0, last_ts + 3);
    idle(6);
    // Holdoff of 5: excursion at +3 ignored, excursion at +7 retriggers
    bus.holdoff_i = 8'd5;
    pair(200, 0);
    p = last_ts;
    pair(0, 0);
    tt = last_ts;
    push(200, p, 1'b0, tt + 3);
    idle(2);
    pair(500, 0);
    idle(3);
    pair(400, 0);
    check("holdoff_boundary_ts", 64'(last_ts), 64'(tt + 7));
    p = last_ts;
    pair(0, 0);
    push(400, p, 1'b0, last_ts + 3);
    idle(12);
    // Sustained excursion: forced trigger every TRACK_MAX pairs, zero holdoff
    bus.holdoff_i = 8'd0;
    s = ecnt;
    push(235, s + 3, 1'b1, s + 6);
    push(285, s + 8, 1'b1, s + 11);
    for (int k = 0; k < 10; k++) pair(200 + 10 * k, 205 + 10 * k);
    idle(8);
    // Disarmed: no trigger
    bus.arm_i = 1'b0;
    idle(2);
    check("disarmed", 64'(bus.armed_o), 64'd0);
    pair(500, 500);
    idle(6);
    bus.arm_i = 1'b1;
    idle(3);
    // Most negative sample: triggers only in magnitude mode
    bus.thresh_i = 16'd1000;
    pair(-32768, 0);
    p = last_ts;
    pair(0, 0);
`ifdef MF_TRIG_ABS_EN
    push(32767, p, 1'b0, last_ts + 3);
`endif
    idle(6);
    // Reset while tracking discards the event
    bus.thresh_i = 16'd100;
    pair(500, 0);
    pair(0, 0);
    pair(0, 0);
    rstn_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_reset_outputs();
    end
    rstn_i = 1'b1;
    idle(6);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
